// File: rtl/tvp_pkg.sv
// Shared definitions for the test vector player: FSM state encodings,
// the default MISR polynomial and the failure counter width.
// Imported by test_vector_player and tvp_misr.
package tvp_pkg;

  localparam int FAIL_CNT_W = 16;

  localparam logic [63:0] DEFAULT_MISR_POLY = 64'h0000_0000_0000_001B;

  typedef logic [2:0] tvp_state_t;

  localparam tvp_state_t ST_IDLE    = 3'd0;
  localparam tvp_state_t ST_FETCH   = 3'd1;
  localparam tvp_state_t ST_LOAD    = 3'd2;
  localparam tvp_state_t ST_SETTLE  = 3'd3;
  localparam tvp_state_t ST_CAPTURE = 3'd4;
  localparam tvp_state_t ST_DONE    = 3'd5;

endpackage

// File: rtl/tvp_misr.sv
// Multiple-input signature register compacting CUT responses.
// Latency: signature reflects data_in one cycle after enable; clear wins over enable.
// Ports: clk, rst_n (async active-low), clear, enable, data_in[RESP_W], sig[RESP_W].
module tvp_misr
  import tvp_pkg::*;
#(
  parameter int                RESP_W = 64,
  parameter logic [RESP_W-1:0] POLY   = RESP_W'(DEFAULT_MISR_POLY)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [RESP_W-1:0] data_in,
  output logic [RESP_W-1:0] sig
);

  logic [RESP_W-1:0] sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else if (clear) begin
      sig_q <= '0;
    end else if (enable) begin
      // Shift left, fold the MSB back through the polynomial, then absorb the response.
      sig_q <= {sig_q[RESP_W-2:0], 1'b0} ^ (sig_q[RESP_W-1] ? POLY : '0) ^ data_in;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/test_vector_player.sv
// Plays stored test vectors into a CUT, compares responses against golden values,
// counts mismatches, records the first failing index and builds a MISR signature.
// Per vector: FETCH, LOAD, SETTLE_CYCLES of SETTLE, CAPTURE (3+SETTLE_CYCLES cycles); all outputs registered.
// Ports: start/abort/num_vectors control; mem_rd_en/mem_addr/mem_rdata to the vector memory;
// cut_in/cut_out to the CUT; busy/done/pass/fail_count/first_fail_*/signature report status.
module test_vector_player
  import tvp_pkg::*;
#(
  parameter int                VEC_W         = 157,
  parameter int                RESP_W        = 64,
  parameter int                ADDR_W        = 10,
  parameter int                SETTLE_CYCLES = 4,
  parameter logic [RESP_W-1:0] MISR_POLY     = RESP_W'(DEFAULT_MISR_POLY)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_W:0]         num_vectors,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [VEC_W+RESP_W-1:0] mem_rdata,
  output logic [VEC_W-1:0]        cut_in,
  input  logic [RESP_W-1:0]       cut_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [FAIL_CNT_W-1:0]   fail_count,
  output logic                    first_fail_valid,
  output logic [ADDR_W-1:0]       first_fail_idx,
  output logic [RESP_W-1:0]       signature
);

  // Counter only ever holds SETTLE_CYCLES-1 down to 0.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  tvp_state_t              state_q, state_d;
  logic [ADDR_W:0]         nvec_q, nvec_d;
  logic [ADDR_W:0]         idx_q, idx_d;
  logic [ADDR_W:0]         idx_inc;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [RESP_W-1:0]       exp_q, exp_d;
  logic [VEC_W-1:0]        cut_in_q, cut_in_d;
  logic                    mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [FAIL_CNT_W-1:0]   fail_q, fail_d;
  logic                    ffv_q, ffv_d;
  logic [ADDR_W-1:0]       ffi_q, ffi_d;
  logic                    misr_clear, misr_enable;

  always_comb begin
    state_d     = state_q;
    nvec_d      = nvec_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    cut_in_d    = cut_in_q;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    ffv_d       = ffv_q;
    ffi_d       = ffi_q;
    misr_clear  = 1'b0;
    misr_enable = 1'b0;
    idx_inc     = idx_q + 1'b1;

    if (abort) begin
      // Result registers keep their partial values; only control state is dropped.
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            nvec_d     = num_vectors;
            idx_d      = '0;
            fail_d     = '0;
            ffv_d      = 1'b0;
            ffi_d      = '0;
            mem_addr_d = '0;
            misr_clear = 1'b1;
            if (num_vectors == '0) begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              // Read strobe is registered, so raise it on entry to FETCH.
              state_d     = ST_FETCH;
              busy_d      = 1'b1;
              done_d      = 1'b0;
              mem_rd_en_d = 1'b1;
            end
          end
        end
        ST_FETCH: begin
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          cut_in_d = mem_rdata[VEC_W+RESP_W-1:RESP_W];
          exp_d    = mem_rdata[RESP_W-1:0];
          cnt_d    = SETTLE_LOAD;
          state_d  = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = ST_CAPTURE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_CAPTURE: begin
          misr_enable = 1'b1;
          if (cut_out != exp_q) begin
            if (fail_q != '1) begin
              fail_d = fail_q + 1'b1;
            end
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffi_d = idx_q[ADDR_W-1:0];
            end
          end
          idx_d = idx_inc;
          if (idx_inc == nvec_q) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d     = ST_FETCH;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = idx_inc[ADDR_W-1:0];
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end

    // Computed from next-state values so pass stays registered yet tracks done.
    pass_d = done_d && (fail_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      nvec_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      cut_in_q    <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= '0;
      ffv_q       <= 1'b0;
      ffi_q       <= '0;
    end else begin
      state_q     <= state_d;
      nvec_q      <= nvec_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      cut_in_q    <= cut_in_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      ffv_q       <= ffv_d;
      ffi_q       <= ffi_d;
    end
  end

  tvp_misr #(
    .RESP_W (RESP_W),
    .POLY   (MISR_POLY)
  ) u_misr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (misr_clear),
    .enable  (misr_enable),
    .data_in (cut_out),
    .sig     (signature)
  );

  assign mem_rd_en        = mem_rd_en_q;
  assign mem_addr         = mem_addr_q;
  assign cut_in           = cut_in_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_count       = fail_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_test_vector_player.sv
// Directed bench for test_vector_player: clean run, corrupted run, zero-length run,
// start while busy, abort mid-settle with replay, and asynchronous reset mid-run.
module tb_test_vector_player;

  localparam int VEC_W  = 157;
  localparam int RESP_W = 64;
  localparam int ADDR_W = 10;
  localparam int SETTLE = 4;
  localparam logic [63:0] POLY = 64'h0000_0000_0000_001B;

  logic                    clk;
  logic                    rst_n;
  logic                    start;
  logic                    abort;
  logic [ADDR_W:0]         num_vectors;
  logic                    mem_rd_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic [VEC_W+RESP_W-1:0] mem_rdata;
  logic [VEC_W-1:0]        cut_in;
  logic [RESP_W-1:0]       cut_out;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic [15:0]             fail_count;
  logic                    first_fail_valid;
  logic [ADDR_W-1:0]       first_fail_idx;
  logic [RESP_W-1:0]       signature;

  logic [VEC_W+RESP_W-1:0] mem [0:15];
  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt = 0;

  test_vector_player #(
    .VEC_W         (VEC_W),
    .RESP_W        (RESP_W),
    .ADDR_W        (ADDR_W),
    .SETTLE_CYCLES (SETTLE),
    .MISR_POLY     (POLY)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .num_vectors      (num_vectors),
    .mem_rd_en        (mem_rd_en),
    .mem_addr         (mem_addr),
    .mem_rdata        (mem_rdata),
    .cut_in           (cut_in),
    .cut_out          (cut_out),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .fail_count       (fail_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_idx   (first_fail_idx),
    .signature        (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr[3:0]];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  function automatic logic [VEC_W-1:0] vec_of(input int i);
    logic [63:0] a;
    logic [63:0] b;
    a = 64'h9E37_79B9_7F4A_7C15 * 64'(i + 1);
    b = 64'hDEAD_BEEF_0000_0000 | 64'(i * 17 + 3);
    return {29'(i * 29 + 7), a, b};
  endfunction

  // Toy combinational CUT.
  function automatic logic [RESP_W-1:0] cut_model(input logic [VEC_W-1:0] v);
    return v[63:0] ^ v[127:64] ^ {35'd0, v[156:128]};
  endfunction

  function automatic logic [63:0] misr_ref(input int n);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < n; i++) begin
      s = {s[62:0], 1'b0} ^ (s[63] ? POLY : 64'd0) ^ cut_model(vec_of(i));
    end
    return s;
  endfunction

  assign cut_out = cut_model(cut_in);

  task automatic fill_mem(input logic [15:0] bad);
    logic [VEC_W-1:0]  v;
    logic [RESP_W-1:0] e;
    for (int i = 0; i < 16; i++) begin
      v = vec_of(i);
      e = cut_model(v);
      if (bad[i]) e = ~e;
      mem[i] = {v, e};
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a start in cycle 0, optionally pulse start again at glitch_cyc,
  // and return the cycle index in which done is first seen.
  task automatic run(input int n, input int glitch_cyc, output int cyc);
    num_vectors = (ADDR_W+1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    chk("c1_busy", 64'(busy), 64'(n != 0));
    chk("c1_rd_en", 64'(mem_rd_en), 64'(n != 0));
    chk("c1_addr", 64'(mem_addr), 64'd0);
    chk("c1_fail_cnt", 64'(fail_count), 64'd0);
    chk("c1_ffv", 64'(first_fail_valid), 64'd0);
    while (done !== 1'b1 && cyc < 500) begin
      start = (cyc == glitch_cyc);
      if (start) num_vectors = (ADDR_W+1)'(5);
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc;
    int rd_snap;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    num_vectors = '0;
    fill_mem(16'h0000);
    #12;
    rst_n = 1'b1;
    tick();

    // Reset values
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_cut_in", 64'(cut_in == '0), 64'd1);
    chk("rst_fail_cnt", 64'(fail_count), 64'd0);
    chk("rst_ffv", 64'(first_fail_valid), 64'd0);
    chk("rst_ffi", 64'(first_fail_idx), 64'd0);
    chk("rst_sig", signature, 64'd0);

    // Three clean vectors
    run(3, -1, cyc);
    chk("t1_done_cycle", 64'(cyc), 64'd22);
    chk("t1_pass", 64'(pass), 64'd1);
    chk("t1_fail_cnt", 64'(fail_count), 64'd0);
    chk("t1_ffv", 64'(first_fail_valid), 64'd0);
    chk("t1_sig", signature, misr_ref(3));
    tick();
    chk("t1_done_held", 64'(done), 64'd1);
    chk("t1_cut_in_held", 64'(cut_in == vec_of(2)), 64'd1);

    // Zero-length run
    rd_snap = rd_cnt;
    run(0, -1, cyc);
    chk("t0_done_cycle", 64'(cyc), 64'd1);
    chk("t0_pass", 64'(pass), 64'd1);
    chk("t0_sig_cleared", signature, 64'd0);
    tick();
    chk("t0_no_reads", 64'(rd_cnt - rd_snap), 64'd0);

    // Start pulse at cycle 5 with a different count must be ignored
    run(3, 5, cyc);
    chk("tb_done_cycle", 64'(cyc), 64'd22);
    chk("tb_pass", 64'(pass), 64'd1);
    chk("tb_sig", signature, misr_ref(3));

    // Five vectors, expected values of 1 and 3 corrupted
    fill_mem(16'h000A);
    run(5, -1, cyc);
    chk("t5_done_cycle", 64'(cyc), 64'd36);
    chk("t5_fail_cnt", 64'(fail_count), 64'd2);
    chk("t5_ffv", 64'(first_fail_valid), 64'd1);
    chk("t5_ffi", 64'(first_fail_idx), 64'd1);
    chk("t5_pass", 64'(pass), 64'd0);
    chk("t5_sig", signature, misr_ref(5));

    // Abort in cycle 18, inside SETTLE of vector 2; vector 1 has already failed
    num_vectors = (ADDR_W+1)'(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 18; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_done", 64'(done), 64'd0);
    chk("ab_pass", 64'(pass), 64'd0);
    chk("ab_fail_cnt_kept", 64'(fail_count), 64'd1);
    chk("ab_ffi_kept", 64'(first_fail_idx), 64'd1);
    tick();
    chk("ab_idle_rd_en", 64'(mem_rd_en), 64'd0);

    // Abort beats a simultaneous start
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("ab_st_busy", 64'(busy), 64'd0);
    chk("ab_st_rd_en", 64'(mem_rd_en), 64'd0);

    // Replay from index 0 with cleared counters
    run(5, -1, cyc);
    chk("rp_done_cycle", 64'(cyc), 64'd36);
    chk("rp_fail_cnt", 64'(fail_count), 64'd2);
    chk("rp_ffi", 64'(first_fail_idx), 64'd1);
    chk("rp_sig", signature, misr_ref(5));

    // Asynchronous reset mid-run
    fill_mem(16'h0000);
    num_vectors = (ADDR_W+1)'(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 16; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_done", 64'(done), 64'd0);
    chk("ar_rd_en", 64'(mem_rd_en), 64'd0);
    chk("ar_addr", 64'(mem_addr), 64'd0);
    chk("ar_cut_in", 64'(cut_in == '0), 64'd1);
    chk("ar_fail_cnt", 64'(fail_count), 64'd0);
    chk("ar_ffv", 64'(first_fail_valid), 64'd0);
    chk("ar_ffi", 64'(first_fail_idx), 64'd0);
    chk("ar_sig", signature, 64'd0);
    #8;
    rst_n = 1'b1;
    rd_snap = rd_cnt;
    for (int c = 0; c < 12; c++) tick();
    chk("ar_no_reads", 64'(rd_cnt - rd_snap), 64'd0);
    chk("ar_idle_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
